// File: rtl/exmem_stage.sv
// EX/MEM + MEM/WB pipeline slice: registers EX results, runs the data-memory handshake, and feeds both forwarding sources.
// Optional byte-lane stores/enables when EXMEM_BYTELANE_EN is defined; otherwise word access only.
module exmem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] EX_inanswer,
    input  logic [DATA_W-1:0] EX_infboutpipe,
    input  logic [DATA_W-1:0] EX_inpcplus8,
    input  logic [REG_W-1:0]  EX_intopipereg5,
    input  logic              EX_inandlink,
    input  logic              EX_inregwrite,
    input  logic              EX_inmemread,
    input  logic              EX_inmemwrite,
    input  logic              EX_inmemtoreg,
    input  logic              EX_inflush,
`ifdef EXMEM_BYTELANE_EN
    input  logic [1:0]        EX_insize,
    output logic [3:0]        dmem_be,
`endif
    output logic [DATA_W-1:0] MEM_outfromEXMEM,
    output logic [REG_W-1:0]  MEM_outEXMEMREGISTERRDRT,
    output logic              MEM_outEXMEMREGWRITE,
    output logic [DATA_W-1:0] MEM_outfromMEMWB,
    output logic [REG_W-1:0]  MEM_outMEMWBREGISTERRDRT,
    output logic              MEM_outMEMWBREGWRITE,
    output logic              MEM_outstall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RDWAIT} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] answer_q, fbout_q, pcplus8_q;
    logic [REG_W-1:0]  rd_q;
    logic              andlink_q, regwrite_q, memread_q, memwrite_q, memtoreg_q;
    logic              memop, access, done, fsm_done, stall;

    // EX/MEM register: a stall holds the MEM instruction and wins over flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            answer_q   <= '0;
            fbout_q    <= '0;
            pcplus8_q  <= '0;
            rd_q       <= '0;
            andlink_q  <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
        end else if (!stall) begin
            if (EX_inflush) begin
                answer_q   <= '0;
                fbout_q    <= '0;
                pcplus8_q  <= '0;
                rd_q       <= '0;
                andlink_q  <= 1'b0;
                regwrite_q <= 1'b0;
                memread_q  <= 1'b0;
                memwrite_q <= 1'b0;
                memtoreg_q <= 1'b0;
            end else begin
                answer_q   <= EX_inanswer;
                fbout_q    <= EX_infboutpipe;
                pcplus8_q  <= EX_inpcplus8;
                rd_q       <= EX_intopipereg5;
                andlink_q  <= EX_inandlink;
                regwrite_q <= EX_inregwrite;
                memread_q  <= EX_inmemread;
                memwrite_q <= EX_inmemwrite;
                memtoreg_q <= EX_inmemtoreg;
            end
        end
    end

    assign memop = memread_q | memwrite_q;

`ifdef EXMEM_BYTELANE_EN
    // Lane logic assumes a 32-bit datapath; misaligned halves complete without touching memory
    logic [1:0] size_q;
    logic       misalign;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            size_q <= 2'b00;
        else if (!stall)
            size_q <= EX_inflush ? 2'b00 : EX_insize;
    end

    always_comb begin
        misalign   = 1'b0;
        dmem_be    = 4'b1111;
        dmem_wdata = fbout_q;
        case (size_q)
            2'b00: begin
                dmem_be    = 4'b0001 << answer_q[1:0];
                dmem_wdata = {4{fbout_q[7:0]}};
            end
            2'b01: begin
                dmem_wdata = {2{fbout_q[15:0]}};
                if (answer_q[0]) begin
                    misalign = 1'b1;
                    dmem_be  = 4'b0000;
                end else begin
                    dmem_be  = answer_q[1] ? 4'b1100 : 4'b0011;
                end
            end
            default: ;
        endcase
    end

    assign access = memop & ~misalign;
`else
    assign dmem_wdata = fbout_q;
    assign access     = memop;
`endif

    assign dmem_addr = answer_q;
    assign dmem_we   = memwrite_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        dmem_req = 1'b0;
        fsm_done = 1'b0;
        case (state)
            IDLE, REQ: begin
                if (access || state == REQ) begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        if (memwrite_q) begin
                            fsm_done = 1'b1;
                            state_n  = IDLE;
                        end else begin
                            state_n  = RDWAIT;
                        end
                    end else begin
                        state_n = REQ;
                    end
                end
            end
            RDWAIT: begin
                if (dmem_rvalid) begin
                    fsm_done = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A memop that never needs the memory (misaligned half) counts as done at once
    assign done         = fsm_done | (memop & ~access);
    assign stall        = memop & ~done;
    assign MEM_outstall = stall;

    assign MEM_outfromEXMEM         = andlink_q ? pcplus8_q : answer_q;
    assign MEM_outEXMEMREGISTERRDRT = rd_q;
    assign MEM_outEXMEMREGWRITE     = regwrite_q;

    // MEM/WB register: stalled cycles insert a regwrite bubble so a held load writes back once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            MEM_outfromMEMWB         <= '0;
            MEM_outMEMWBREGISTERRDRT <= '0;
            MEM_outMEMWBREGWRITE     <= 1'b0;
        end else if (!stall) begin
            MEM_outfromMEMWB         <= memtoreg_q ? dmem_rdata : MEM_outfromEXMEM;
            MEM_outMEMWBREGISTERRDRT <= rd_q;
            MEM_outMEMWBREGWRITE     <= regwrite_q;
        end else begin
            MEM_outMEMWBREGWRITE     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exmem_stage.sv
// Directed bench for exmem_stage: forwarding, store/load handshakes, flush, and reset mid-access.
module tb_exmem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] EX_inanswer, EX_infboutpipe, EX_inpcplus8;
    logic [4:0]  EX_intopipereg5;
    logic        EX_inandlink, EX_inregwrite, EX_inmemread, EX_inmemwrite, EX_inmemtoreg, EX_inflush;
    logic [31:0] MEM_outfromEXMEM, MEM_outfromMEMWB;
    logic [4:0]  MEM_outEXMEMREGISTERRDRT, MEM_outMEMWBREGISTERRDRT;
    logic        MEM_outEXMEMREGWRITE, MEM_outMEMWBREGWRITE, MEM_outstall;
    logic        dmem_req, dmem_we, dmem_ready, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
`ifdef EXMEM_BYTELANE_EN
    logic [1:0]  EX_insize;
    logic [3:0]  dmem_be;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int stall_cnt;
    int wb_pulses;

    always #5 clk = ~clk;

    exmem_stage dut (
        .clk(clk), .reset(reset),
        .EX_inanswer(EX_inanswer), .EX_infboutpipe(EX_infboutpipe), .EX_inpcplus8(EX_inpcplus8),
        .EX_intopipereg5(EX_intopipereg5), .EX_inandlink(EX_inandlink), .EX_inregwrite(EX_inregwrite),
        .EX_inmemread(EX_inmemread), .EX_inmemwrite(EX_inmemwrite), .EX_inmemtoreg(EX_inmemtoreg),
        .EX_inflush(EX_inflush),
`ifdef EXMEM_BYTELANE_EN
        .EX_insize(EX_insize), .dmem_be(dmem_be),
`endif
        .MEM_outfromEXMEM(MEM_outfromEXMEM), .MEM_outEXMEMREGISTERRDRT(MEM_outEXMEMREGISTERRDRT),
        .MEM_outEXMEMREGWRITE(MEM_outEXMEMREGWRITE), .MEM_outfromMEMWB(MEM_outfromMEMWB),
        .MEM_outMEMWBREGISTERRDRT(MEM_outMEMWBREGISTERRDRT), .MEM_outMEMWBREGWRITE(MEM_outMEMWBREGWRITE),
        .MEM_outstall(MEM_outstall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] ans, input logic [31:0] fb, input logic [31:0] pc8,
                          input logic [4:0] rd, input logic lnk, input logic rw, input logic mr,
                          input logic mw, input logic m2r);
        EX_inanswer     = ans;
        EX_infboutpipe  = fb;
        EX_inpcplus8    = pc8;
        EX_intopipereg5 = rd;
        EX_inandlink    = lnk;
        EX_inregwrite   = rw;
        EX_inmemread    = mr;
        EX_inmemwrite   = mw;
        EX_inmemtoreg   = m2r;
    endtask

    initial begin
        reset = 1'b1;
        EX_inflush = 1'b0;
        dmem_ready = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata = 32'h0;
`ifdef EXMEM_BYTELANE_EN
        EX_insize = 2'b10;
`endif
        set_ex(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_exmem_val", MEM_outfromEXMEM, 32'h0);
        chk("rst_exmem_rw", {31'h0, MEM_outEXMEMREGWRITE}, 32'h0);
        chk("rst_memwb_val", MEM_outfromMEMWB, 32'h0);
        chk("rst_memwb_rw", {31'h0, MEM_outMEMWBREGWRITE}, 32'h0);
        chk("rst_stall", {31'h0, MEM_outstall}, 32'h0);
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        reset = 1'b0;

        // add r3 = 0x1234
        set_ex(32'h1234, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("add_exmem_val", MEM_outfromEXMEM, 32'h1234);
        chk("add_exmem_reg", {27'h0, MEM_outEXMEMREGISTERRDRT}, 32'd3);
        chk("add_exmem_rw", {31'h0, MEM_outEXMEMREGWRITE}, 32'd1);
        chk("add_stall", {31'h0, MEM_outstall}, 32'h0);
        set_ex(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("add_memwb_val", MEM_outfromMEMWB, 32'h1234);
        chk("add_memwb_reg", {27'h0, MEM_outMEMWBREGISTERRDRT}, 32'd3);
        chk("add_memwb_rw", {31'h0, MEM_outMEMWBREGWRITE}, 32'd1);
        chk("nop_exmem_rw", {31'h0, MEM_outEXMEMREGWRITE}, 32'h0);

        // jal: link value replaces the ALU result
        set_ex(32'hAAAA, 32'h0, 32'h108, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("jal_exmem_val", MEM_outfromEXMEM, 32'h108);
        chk("jal_exmem_reg", {27'h0, MEM_outEXMEMREGISTERRDRT}, 32'd31);

        // sw with zero-wait accept
        set_ex(32'h80, 32'hDEADBEEF, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        dmem_ready = 1'b1;
        tick();
        chk("sw_req", {31'h0, dmem_req}, 32'd1);
        chk("sw_we", {31'h0, dmem_we}, 32'd1);
        chk("sw_addr", dmem_addr, 32'h80);
        chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("sw_stall", {31'h0, MEM_outstall}, 32'h0);
        chk("jal_memwb_val", MEM_outfromMEMWB, 32'h108);
        set_ex(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("sw_req_drop", {31'h0, dmem_req}, 32'h0);
        chk("sw_memwb_rw", {31'h0, MEM_outMEMWBREGWRITE}, 32'h0);
        dmem_ready = 1'b0;

        // lw r7 @0x40: ready in cycle 2, stray rvalid in cycle 1, real rvalid in cycle 5
        set_ex(32'h40, 32'h0, 32'h0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("lw_addr", dmem_addr, 32'h40);
        chk("lw_we", {31'h0, dmem_we}, 32'h0);
        set_ex(32'h55, 32'h0, 32'h0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        stall_cnt = 0;
        wb_pulses = 0;
        for (int c = 0; c < 12; c++) begin
            dmem_ready  = (c == 2);
            dmem_rvalid = (c == 1) || (c == 5);
            dmem_rdata  = (c == 5) ? 32'hCAFEF00D : 32'h0BAD0BAD;
            EX_inflush  = (c < 5);
            #1;
            if (MEM_outstall) stall_cnt++;
            if (MEM_outMEMWBREGWRITE) wb_pulses++;
            if (!MEM_outstall) begin
                tick();
                break;
            end
            tick();
        end
        dmem_ready = 1'b0;
        dmem_rvalid = 1'b0;
        EX_inflush = 1'b0;
        chk("lw_stall_cycles", stall_cnt, 32'd5);
        chk("lw_no_early_wb", wb_pulses, 32'd0);
        chk("lw_memwb_val", MEM_outfromMEMWB, 32'hCAFEF00D);
        chk("lw_memwb_reg", {27'h0, MEM_outMEMWBREGISTERRDRT}, 32'd7);
        chk("lw_memwb_rw", {31'h0, MEM_outMEMWBREGWRITE}, 32'd1);
        chk("post_lw_exmem", MEM_outfromEXMEM, 32'h55);
        set_ex(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("post_lw_wb_val", MEM_outfromMEMWB, 32'h55);
        chk("post_lw_wb_reg", {27'h0, MEM_outMEMWBREGISTERRDRT}, 32'd5);

        // flush with stall low loads a bubble
        set_ex(32'h99, 32'h0, 32'h0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        EX_inflush = 1'b1;
        tick();
        EX_inflush = 1'b0;
        chk("flush_val", MEM_outfromEXMEM, 32'h0);
        chk("flush_reg", {27'h0, MEM_outEXMEMREGISTERRDRT}, 32'h0);
        chk("flush_rw", {31'h0, MEM_outEXMEMREGWRITE}, 32'h0);

        // reset while waiting for read data
        set_ex(32'h44, 32'h0, 32'h0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        dmem_ready = 1'b1;
        tick();
        set_ex(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        dmem_ready = 1'b0;
        chk("rdwait_req", {31'h0, dmem_req}, 32'h0);
        chk("rdwait_stall", {31'h0, MEM_outstall}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_stall", {31'h0, MEM_outstall}, 32'h0);
        chk("arst_req", {31'h0, dmem_req}, 32'h0);
        tick();
        reset = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h12345678;
        tick();
        dmem_rvalid = 1'b0;
        chk("late_rvalid_rw", {31'h0, MEM_outMEMWBREGWRITE}, 32'h0);
        chk("late_rvalid_val", MEM_outfromMEMWB, 32'h0);
        chk("late_rvalid_stall", {31'h0, MEM_outstall}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
